// File: rtl/mem_bus_loader_pkg.sv
// Shared constants for the byte-stream memory loader: command and response
// bytes, FSM state encodings and a small byte-select helper. The host-side
// tooling and the top level import this package.
package mem_bus_loader_pkg;

  // Command bytes arriving from the UART receiver
  localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'

  // Response bytes returned to the host
  localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ALIGN   = 8'h41;  // 'A' unaligned address
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?' unknown command
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T' bus timeout

  // FSM state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_BUS  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // Select byte i of a word, little-endian (byte 0 = bits 7:0)
  function automatic logic [7:0] le_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_bus_loader.sv
// Byte-stream driven initiator for the mem_valid/mem_ready bus.
// Parses 'W' addr[4] data[4] and 'R' addr[4] commands (little-endian) from
// the UART receiver and issues single-word transactions, then returns a
// response byte sequence on the tx side.
//
// Handshakes: a byte moves on rx when i_rx_valid && o_rx_ready at posedge,
// and on tx when o_tx_valid && i_tx_ready at posedge. On the memory bus
// o_mem_valid is held with constant addr/wdata/wstrb until the edge where
// i_mem_ready is sampled high; o_mem_valid is low the following cycle.
module mem_bus_loader
  import mem_bus_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata,
  output logic        o_active,
  output logic [2:0]  o_dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter starts at 0 in the first BUS cycle, so the final allowed
  // cycle is the one where it holds TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    r_state;
  logic [1:0]    r_cnt;
  logic          r_is_write;
  logic          r_align_err;
  logic [31:0]   r_addr_sh;
  logic [31:0]   r_data_sh;
  logic [CW-1:0] r_to_cnt;
  logic [31:0]   r_rdata;
  logic [2:0]    r_resp_idx;
  logic [2:0]    r_resp_last;

  logic          r_rx_ready;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic          r_mem_valid;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wstrb;
  logic          r_active;

  logic          w_rx_fire;
  logic          w_tx_fire;
  logic [31:0]   w_addr_next;
  logic [31:0]   w_data_next;

  assign w_rx_fire   = i_rx_valid && r_rx_ready;
  assign w_tx_fire   = r_tx_valid && i_tx_ready;
  assign w_addr_next = {i_rx_data, r_addr_sh[31:8]};
  assign w_data_next = {i_rx_data, r_data_sh[31:8]};

  // Command parser, bus sequencer and response generator
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_is_write  <= 1'b0;
      r_align_err <= 1'b0;
      r_addr_sh   <= 32'd0;
      r_data_sh   <= 32'd0;
      r_to_cnt    <= '0;
      r_rdata     <= 32'd0;
      r_resp_idx  <= 3'd0;
      r_resp_last <= 3'd0;
      r_rx_ready  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'd0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_active    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Also raises rx_ready in the first cycle after reset
          r_rx_ready <= 1'b1;
          if (w_rx_fire) begin
            r_active    <= 1'b1;
            r_cnt       <= 2'd0;
            r_align_err <= 1'b0;
            if (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ) begin
              r_is_write <= (i_rx_data == CMD_WRITE);
              r_state    <= ST_ADDR;
            end else begin
              r_state     <= ST_RESP;
              r_rx_ready  <= 1'b0;
              r_tx_valid  <= 1'b1;
              r_tx_data   <= RSP_UNKNOWN;
              r_resp_idx  <= 3'd0;
              r_resp_last <= 3'd0;
            end
          end
        end

        ST_ADDR: begin
          if (w_rx_fire) begin
            r_addr_sh <= w_addr_next;
            r_cnt     <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              if (r_is_write) begin
                // Data bytes are still consumed even if the address is bad
                r_state     <= ST_DATA;
                r_align_err <= (w_addr_next[1:0] != 2'b00);
              end else if (w_addr_next[1:0] != 2'b00) begin
                r_state     <= ST_RESP;
                r_rx_ready  <= 1'b0;
                r_tx_valid  <= 1'b1;
                r_tx_data   <= RSP_ALIGN;
                r_resp_idx  <= 3'd0;
                r_resp_last <= 3'd0;
              end else begin
                r_state     <= ST_BUS;
                r_rx_ready  <= 1'b0;
                r_mem_valid <= 1'b1;
                r_mem_addr  <= w_addr_next;
                r_mem_wdata <= 32'd0;
                r_mem_wstrb <= 4'b0000;
                r_to_cnt    <= '0;
              end
            end
          end
        end

        ST_DATA: begin
          if (w_rx_fire) begin
            r_data_sh <= w_data_next;
            r_cnt     <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_rx_ready <= 1'b0;
              if (r_align_err) begin
                r_state     <= ST_RESP;
                r_tx_valid  <= 1'b1;
                r_tx_data   <= RSP_ALIGN;
                r_resp_idx  <= 3'd0;
                r_resp_last <= 3'd0;
              end else begin
                r_state     <= ST_BUS;
                r_mem_valid <= 1'b1;
                r_mem_addr  <= r_addr_sh;
                r_mem_wdata <= w_data_next;
                r_mem_wstrb <= 4'b1111;
                r_to_cnt    <= '0;
              end
            end
          end
        end

        ST_BUS: begin
          // A ready in the final allowed cycle still counts as success
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            r_rdata     <= i_mem_rdata;
            r_state     <= ST_RESP;
            r_tx_valid  <= 1'b1;
            r_tx_data   <= RSP_OK;
            r_resp_idx  <= 3'd0;
            r_resp_last <= r_is_write ? 3'd0 : 3'd4;
          end else if (r_to_cnt == TO_LAST) begin
            r_mem_valid <= 1'b0;
            r_state     <= ST_RESP;
            r_tx_valid  <= 1'b1;
            r_tx_data   <= RSP_TIMEOUT;
            r_resp_idx  <= 3'd0;
            r_resp_last <= 3'd0;
          end else begin
            r_to_cnt <= r_to_cnt + CW'(1);
          end
        end

        ST_RESP: begin
          if (w_tx_fire) begin
            if (r_resp_idx == r_resp_last) begin
              r_state    <= ST_IDLE;
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'd0;
              r_active   <= 1'b0;
              r_rx_ready <= 1'b1;
            end else begin
              // Index 1..4 carries read data byte 0..3
              r_resp_idx <= r_resp_idx + 3'd1;
              r_tx_data  <= le_byte(r_rdata, r_resp_idx[1:0]);
            end
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready  = r_rx_ready;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_data   = r_tx_data;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;
  assign o_active    = r_active;
  assign o_dbg_state = r_state;

endmodule

// File: doc/mem_bus_loader.md
# mem_bus_loader

Byte-stream-driven initiator for the mem_valid/mem_ready memory bus: parses simple word read/write commands arriving from a UART receiver byte stream and issues single-word transactions to the BRAM controller or any other bus responder. Used to replace the seed firmware in BRAM at runtime and to peek/poke memory for debug. The top level muxes the bus to this block and holds the CPU while `active` is high.

## Interface
- TIMEOUT_CYCLES, 1024: maximum cycles mem_valid is held waiting for mem_ready before abort; counter width $clog2(TIMEOUT_CYCLES+1).
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- rx_valid  in  1  command byte available.
- rx_data  in  8  command byte.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready at posedge.
- tx_valid  out  1  response byte available.
- tx_data  out  8  response byte.
- tx_ready  in  1  byte consumed when tx_valid && tx_ready at posedge.
- mem_valid  out  1  bus request.
- mem_ready  in  1  responder completion pulse.
- mem_addr  out  32  word address (bits 1:0 always 0 while mem_valid).
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 write, 4'b0000 read.
- mem_rdata  in  32  read data, valid in the mem_ready cycle.
- active  out  1  high from command byte accept until final response byte consumed.

## Operation
- Commands: 0x57 'W' + addr[4 bytes LE] + data[4 bytes LE]; 0x52 'R' + addr[4 bytes LE].
- Responses: write OK 0x4B; read OK 0x4B then rdata 4 bytes LE; unaligned address (addr[1:0]!=0) 0x41, no bus access; unknown command 0x3F; bus timeout 0x54.
- States: IDLE, ADDR (byte cnt 0-3), DATA (byte cnt 0-3), BUS, RESP (byte index 0-4, last index 0 or 4).
- IDLE: accept byte; 'W'/'R' -> ADDR; other -> RESP with 0x3F (no further bytes consumed for that command).
- ADDR: shift bytes LE; on 4th byte: unaligned -> RESP 0x41 (for 'W' the 4 data bytes are still consumed in DATA first, then 0x41); 'W' -> DATA; 'R' -> BUS.
- DATA: on 4th byte -> BUS.
- BUS: mem_valid=1, addr/wdata/wstrb held constant; mem_ready=1 -> capture mem_rdata (read), mem_valid=0 next cycle, -> RESP 0x4B. Timeout counter reaches TIMEOUT_CYCLES -> RESP 0x54.
- RESP: present bytes in order; after last byte consumed -> IDLE.
- rx_ready=1 only in IDLE, ADDR, DATA; tx_valid=1 only in RESP.

## Timing
- Reset values: rx_ready 0 during reset, 1 the first cycle after; tx_valid 0, tx_data 0, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, active 0; state IDLE, counters 0.
- All outputs registered. mem_valid rises the cycle after the last command byte is accepted.
- mem_valid falls on the edge where mem_ready is sampled high; never high in the cycle after a ready (responder must not see a new request). Back-to-back bus requests impossible (minimum one RESP cycle between).
- Against the BRAM controller: mem_valid high exactly 4 cycles per access.
- Timeout: counter cleared on entering BUS, increments each BUS cycle; mem_ready in the same cycle the counter hits limit -> success wins.
- tx back-pressure: tx_data stable while tx_valid && !tx_ready; rx stalled (rx_ready=0).
- Reset mid-operation: next edge returns to IDLE, mem_valid 0 that cycle; partially received command discarded; responder is reset together at top level.
- Response latency: first response byte valid the cycle after mem_ready (or after error detection).

## Structure
- Shared package: command/response byte constants (CMD_WRITE, CMD_READ, RSP_OK, RSP_ALIGN, RSP_UNKNOWN, RSP_TIMEOUT) and the state enum, so the host-side tooling testbench and top level reuse them.
- Single module; no sub-module needed.

## Test plan
- Write 57 00 01 00 00 EF BE AD DE with BRAM controller -> mem_addr 0x00000100, mem_wdata 0xDEADBEEF, wstrb 1111, mem_valid high 4 cycles, tx 0x4B; following read of 0x100 -> tx 4B EF BE AD DE.
- Read 52 04 00 00 00, stub responder readies after 7 cycles with 0x12345678 -> mem_valid high 8 cycles, wstrb 0000, tx 4B 78 56 34 12.
- Read addr 0x00000102 -> mem_valid never asserted, tx 0x41; unknown byte 0x00 -> tx 0x3F, next byte 0x52 parsed as new command.
- TIMEOUT_CYCLES=16, responder never ready -> mem_valid high exactly 16 cycles, tx 0x54, then IDLE; ready on cycle 16 -> tx 0x4B.
- tx_ready low 10 cycles during read response -> tx_data held at 0x4B, rx_ready 0, bytes then delivered in order.
- reset_n low for one cycle mid-BUS -> mem_valid 0, active 0, tx_valid 0 next cycle; subsequent write completes normally.
